// File: rtl/mem_map_pkg.sv
// Shared memory-map, select-code and funct3 definitions for the
// data-memory access path.
package mem_map_pkg;

    localparam logic [3:0] REGION_DMEM = 4'b0001;
    localparam logic [3:0] REGION_BIOS = 4'b0100;
    localparam logic [3:0] REGION_IO   = 4'b1000;

    localparam logic [1:0] DMEM_SEL_IO   = 2'd0;
    localparam logic [1:0] DMEM_SEL_DMEM = 2'd1;
    localparam logic [1:0] DMEM_SEL_BIOS = 2'd2;

    localparam logic [1:0] WB_SEL_IMM = 2'd0;
    localparam logic [1:0] WB_SEL_PC4 = 2'd1;
    localparam logic [1:0] WB_SEL_MEM = 2'd2;
    localparam logic [1:0] WB_SEL_ALU = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef logic [1:0] io_state_t;
    localparam io_state_t ST_IDLE    = 2'd0;
    localparam io_state_t ST_IO_WAIT = 2'd1;
    localparam io_state_t ST_IO_DONE = 2'd2;

    // Unmapped addresses fall back to the DMEM raw-data path.
    function automatic logic [1:0] dmem_sel_of(input logic [3:0] nib);
        if (nib == REGION_IO)
            return DMEM_SEL_IO;
        else if (nib == REGION_BIOS)
            return DMEM_SEL_BIOS;
        return DMEM_SEL_DMEM;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_store_lane_gen.sv
// Store byte-lane generator: funct3 and address low bits to byte
// write-enables, lane-aligned data and a misalignment flag.
module store_lane_gen
    import mem_map_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  we,
    output logic [31:0] data,
    output logic        misaligned
);

    always_comb begin
        we         = 4'b0000;
        data       = 32'h0;
        misaligned = 1'b0;
        case (funct3)
            F3_SB: begin
                we   = 4'b0001 << addr_lo;
                data = {4{wdata[7:0]}};
            end
            F3_SH: begin
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else begin
                    we   = addr_lo[1] ? 4'b1100 : 4'b0011;
                    data = {2{wdata[15:0]}};
                end
            end
            F3_SW: begin
                if (addr_lo != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    we   = 4'b1111;
                    data = wdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// EXE-stage data-memory access sequencer: region decode, DMEM lanes,
// IO req/ack with timeout, and WB select alignment registers.
module mem_access_ctrl
    import mem_map_pkg::*;
#(
    parameter int IO_TIMEOUT = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_is_load,
    input  logic              exe_is_store,
    input  logic [2:0]        exe_funct3,
    input  logic [1:0]        exe_wb_sel,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [31:0]       exe_wdata,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [31:0]       dmem_wdata,
    output logic              bios_en,
    output logic              io_req,
    output logic              io_we,
    output logic [ADDR_W-1:0] io_addr,
    output logic [31:0]       io_wdata,
    input  logic              io_ack,
    input  logic [31:0]       io_rdata,
    output logic [31:0]       io_data_q,
    output logic              stall,
    output logic [1:0]        wb_dmem_sel,
    output logic [2:0]        wb_load_sel,
    output logic [1:0]        wb_sel,
    output logic              misalign
);

    localparam int CNT_W = ($clog2(IO_TIMEOUT) < 5) ? 5 : $clog2(IO_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    io_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              io_we_q, io_we_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [31:0]       io_wdata_q, io_wdata_d;
    logic [31:0]       io_data_d, io_data_r;
    logic              misalign_q, misalign_d;
    logic [1:0]        wb_dmem_sel_q, wb_dmem_sel_d;
    logic [2:0]        wb_load_sel_q, wb_load_sel_d;
    logic [1:0]        wb_sel_q, wb_sel_d;

    logic [3:0]  nib;
    logic        mem_op, waiting, io_start, dmem_st;
    logic [3:0]  lane_we;
    logic [31:0] lane_data;
    logic        lane_mis;

    assign nib      = exe_addr[ADDR_W-1 -: 4];
    assign mem_op   = exe_is_load | exe_is_store;
    assign waiting  = (state_q == ST_IO_WAIT);
    assign io_start = exe_valid & (nib == REGION_IO) & mem_op & (state_q == ST_IDLE);
    assign dmem_st  = exe_valid & (nib == REGION_DMEM) & exe_is_store & ~waiting;

    store_lane_gen u_lane (
        .funct3     (exe_funct3),
        .addr_lo    (exe_addr[1:0]),
        .wdata      (exe_wdata),
        .we         (lane_we),
        .data       (lane_data),
        .misaligned (lane_mis)
    );

    assign dmem_en    = exe_valid & (nib == REGION_DMEM) & mem_op & ~waiting;
    assign dmem_we    = dmem_st ? lane_we : 4'b0000;
    assign dmem_wdata = dmem_st ? lane_data : 32'h0;
    assign bios_en    = exe_valid & (nib == REGION_BIOS) & exe_is_load & ~waiting;
    assign stall      = io_start | waiting;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        io_we_d    = io_we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        io_data_d  = io_data_r;
        misalign_d = misalign_q | (dmem_st & lane_mis);
        case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    state_d    = ST_IO_WAIT;
                    cnt_d      = '0;
                    io_we_d    = exe_is_store;
                    io_addr_d  = exe_addr;
                    io_wdata_d = exe_wdata;
                end
            end
            ST_IO_WAIT: begin
                // Ack takes priority over a coincident timeout.
                if (io_ack) begin
                    if (!io_we_q)
                        io_data_d = io_rdata;
                    state_d = ST_IO_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    io_data_d  = 32'h0;
                    misalign_d = 1'b1;
                    state_d    = ST_IO_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IO_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_dmem_sel_d = wb_dmem_sel_q;
        wb_load_sel_d = wb_load_sel_q;
        wb_sel_d      = wb_sel_q;
        if (!stall) begin
            if (!exe_valid) begin
                wb_dmem_sel_d = 2'd0;
                wb_load_sel_d = 3'd0;
                wb_sel_d      = 2'd0;
            end else begin
                wb_dmem_sel_d = dmem_sel_of(nib);
                wb_load_sel_d = exe_funct3;
                wb_sel_d      = exe_wb_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            io_we_q       <= 1'b0;
            io_addr_q     <= '0;
            io_wdata_q    <= 32'h0;
            io_data_r     <= 32'h0;
            misalign_q    <= 1'b0;
            wb_dmem_sel_q <= 2'd0;
            wb_load_sel_q <= 3'd0;
            wb_sel_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            io_we_q       <= io_we_d;
            io_addr_q     <= io_addr_d;
            io_wdata_q    <= io_wdata_d;
            io_data_r     <= io_data_d;
            misalign_q    <= misalign_d;
            wb_dmem_sel_q <= wb_dmem_sel_d;
            wb_load_sel_q <= wb_load_sel_d;
            wb_sel_q      <= wb_sel_d;
        end
    end

    assign io_req      = waiting;
    assign io_we       = io_we_q;
    assign io_addr     = io_addr_q;
    assign io_wdata    = io_wdata_q;
    assign io_data_q   = io_data_r;
    assign misalign    = misalign_q;
    assign wb_dmem_sel = wb_dmem_sel_q;
    assign wb_load_sel = wb_load_sel_q;
    assign wb_sel      = wb_sel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, IO sequences and
// randomized non-IO traffic against an address-arithmetic model.
module tb_mem_access_ctrl;
    import mem_map_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid, exe_is_load, exe_is_store;
    logic [2:0]  exe_funct3;
    logic [1:0]  exe_wb_sel;
    logic [31:0] exe_addr, exe_wdata;
    logic        dmem_en, bios_en, io_req, io_we, io_ack, stall, misalign;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata, io_addr, io_wdata, io_rdata, io_data_q;
    logic [1:0]  wb_dmem_sel, wb_sel;
    logic [2:0]  wb_load_sel;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.IO_TIMEOUT(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_is_load(exe_is_load),
        .exe_is_store(exe_is_store), .exe_funct3(exe_funct3),
        .exe_wb_sel(exe_wb_sel), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .bios_en(bios_en), .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack),
        .io_rdata(io_rdata), .io_data_q(io_data_q), .stall(stall),
        .wb_dmem_sel(wb_dmem_sel), .wb_load_sel(wb_load_sel),
        .wb_sel(wb_sel), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, ld, st;
        logic [2:0]  f3;
        logic [1:0]  ws;
        logic [31:0] a, d;
        logic        en;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        ben;
        logic [1:0]  dsel;
        logic        mis;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [1:0] ws,
                         input logic [31:0] a, input logic [31:0] d);
        exe_valid = v; exe_is_load = ld; exe_is_store = st;
        exe_funct3 = f3; exe_wb_sel = ws; exe_addr = a; exe_wdata = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0);
        io_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void model(
        input logic v, input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] d,
        output logic en, output logic [3:0] we, output logic [31:0] wd,
        output logic ben, output logic mis, output logic [1:0] dsel);
        int unsigned nib, off, sz;
        nib = a >> 28;
        off = a % 4;
        sz  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        en  = v && nib == 1 && (ld || st);
        ben = v && nib == 4 && ld;
        dsel = !v ? 2'd0 : (nib == 8) ? 2'd0 : (nib == 4) ? 2'd2 : 2'd1;
        we = 4'd0; wd = 32'h0; mis = 1'b0;
        if (v && nib == 1 && st && sz != 0) begin
            if (off % sz != 0) begin
                mis = 1'b1;
            end else begin
                we = 4'(((1 << sz) - 1) << off);
                wd = (sz == 1) ? d[7:0] * 32'h0101_0101 :
                     (sz == 2) ? d[15:0] * 32'h0001_0001 : d;
            end
        end
    endfunction

    // Holds an IO instruction in EXE until the stall releases.
    task automatic run_io(input int ack_at, input logic [31:0] a,
                          input logic wr, input logic [31:0] d,
                          output int n_stall, output int n_req,
                          output bit done);
        n_stall = 0; n_req = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (io_req) begin
                n_req++;
                if (n_req == 1) begin
                    chk("io_addr", io_addr, a);
                    chk("io_we", 32'(io_we), 32'(wr));
                    if (wr) chk("io_wdata", io_wdata, d);
                end
            end
            io_ack   = io_req && (n_req == ack_at);
            io_rdata = 32'hDEAD_BEEF;
            if (stall) n_stall++;
            else if (n_stall > 0) done = 1;
            if (!done) @(negedge clk);
        end
        io_ack = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL io_release got=no_release want=release");
        end
    endtask

    initial begin
        logic        en, ben, mis, exp_mis;
        logic [3:0]  we;
        logic [31:0] wd, exp_ioq;
        logic [1:0]  dsel;
        logic [3:0]  nib;
        int          ns, nr;
        bit          ok;

        rst = 1'b1; io_ack = 1'b0; io_rdata = 32'h0;
        drive(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0);
        do_reset();
        #1;
        chk("rst_io_req", 32'(io_req), 0);
        chk("rst_io_we", 32'(io_we), 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_io_wdata", io_wdata, 0);
        chk("rst_io_data_q", io_data_q, 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb", {27'd0, wb_dmem_sel, wb_load_sel}, 0);
        chk("rst_wb_sel", 32'(wb_sel), 0);

        tbl[0] = '{1, 0, 1, F3_SB, WB_SEL_ALU, 32'h1000_0003, 32'h0000_00AB,
                   1, 4'b1000, 32'hABAB_ABAB, 0, DMEM_SEL_DMEM, 0};
        tbl[1] = '{1, 1, 0, F3_LHU, WB_SEL_MEM, 32'h4000_0010, 32'h0,
                   0, 4'b0000, 32'h0, 1, DMEM_SEL_BIOS, 0};
        tbl[2] = '{1, 0, 1, F3_SH, WB_SEL_IMM, 32'h1000_0002, 32'h0000_1234,
                   1, 4'b1100, 32'h1234_1234, 0, DMEM_SEL_DMEM, 0};
        tbl[3] = '{0, 0, 1, F3_SB, WB_SEL_PC4, 32'h1000_0000, 32'h11,
                   0, 4'b0000, 32'h0, 0, DMEM_SEL_IO, 0};
        tbl[4] = '{1, 1, 0, F3_LB, WB_SEL_PC4, 32'h2000_0000, 32'h0,
                   0, 4'b0000, 32'h0, 0, DMEM_SEL_DMEM, 0};
        tbl[5] = '{1, 0, 1, F3_SW, WB_SEL_ALU, 32'h4000_0000, 32'h77,
                   0, 4'b0000, 32'h0, 0, DMEM_SEL_BIOS, 0};
        tbl[6] = '{1, 1, 0, F3_LBU, WB_SEL_MEM, 32'h1000_0001, 32'h0,
                   1, 4'b0000, 32'h0, 0, DMEM_SEL_DMEM, 0};
        tbl[7] = '{1, 0, 1, F3_SW, WB_SEL_ALU, 32'h1000_0002, 32'h55,
                   1, 4'b0000, 32'h0, 0, DMEM_SEL_DMEM, 1};
        tbl[8] = '{1, 0, 1, F3_SW, WB_SEL_ALU, 32'h1000_0004, 32'hCAFE_F00D,
                   1, 4'b1111, 32'hCAFE_F00D, 0, DMEM_SEL_DMEM, 1};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].ws,
                  tbl[i].a, tbl[i].d);
            #1;
            chk($sformatf("t%0d_dmem_en", i), 32'(dmem_en), 32'(tbl[i].en));
            chk($sformatf("t%0d_dmem_we", i), 32'(dmem_we), 32'(tbl[i].we));
            chk($sformatf("t%0d_dmem_wdata", i), dmem_wdata, tbl[i].wd);
            chk($sformatf("t%0d_bios_en", i), 32'(bios_en), 32'(tbl[i].ben));
            chk($sformatf("t%0d_stall", i), 32'(stall), 0);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_wb_dmem_sel", i), 32'(wb_dmem_sel), 32'(tbl[i].dsel));
            chk($sformatf("t%0d_wb_load_sel", i), 32'(wb_load_sel),
                tbl[i].v ? 32'(tbl[i].f3) : 0);
            chk($sformatf("t%0d_wb_sel", i), 32'(wb_sel), tbl[i].v ? 32'(tbl[i].ws) : 0);
            chk($sformatf("t%0d_misalign", i), 32'(misalign), 32'(tbl[i].mis));
        end

        do_reset();
        drive(1, 1, 0, F3_LW, WB_SEL_MEM, 32'h8000_0008, 32'h0);
        run_io(2, 32'h8000_0008, 1'b0, 32'h0, ns, nr, ok);
        chk("ioack_stall_cycles", ns, 3);
        chk("ioack_req_cycles", nr, 2);
        chk("ioack_data_q", io_data_q, 32'hDEAD_BEEF);
        chk("ioack_req_done", 32'(io_req), 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0);
        chk("ioack_wb_dmem_sel", 32'(wb_dmem_sel), 32'(DMEM_SEL_IO));
        chk("ioack_wb_load_sel", 32'(wb_load_sel), 32'(F3_LW));
        chk("ioack_wb_sel", 32'(wb_sel), 32'(WB_SEL_MEM));
        chk("ioack_misalign", 32'(misalign), 0);

        @(negedge clk);
        drive(1, 0, 1, F3_SW, WB_SEL_ALU, 32'h8000_0100, 32'h1234_5678);
        run_io(0, 32'h8000_0100, 1'b1, 32'h1234_5678, ns, nr, ok);
        chk("tmo_req_cycles", nr, 16);
        chk("tmo_stall_cycles", ns, 17);
        chk("tmo_misalign", 32'(misalign), 1);
        chk("tmo_data_q", io_data_q, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0);

        do_reset();
        drive(1, 1, 0, F3_LW, WB_SEL_ALU, 32'h1000_0000, 32'h0);
        @(negedge clk);
        drive(1, 1, 0, F3_LH, WB_SEL_MEM, 32'h8000_0040, 32'h0);
        for (int c = 0; c < 3; c++) @(negedge clk);
        #1;
        chk("rmid_req_before", 32'(io_req), 1);
        chk("rmid_wb_sel_before", 32'(wb_sel), 32'(WB_SEL_ALU));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid_io_req", 32'(io_req), 0);
        chk("rmid_wb", {27'd0, wb_dmem_sel, wb_load_sel}, 0);
        chk("rmid_wb_sel", 32'(wb_sel), 0);
        chk("rmid_data_q", io_data_q, 0);
        rst = 1'b0;
        drive(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0);
        #1;
        chk("rmid_stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("rmid_bubble_wb_sel", 32'(wb_sel), 0);
        chk("rmid_bubble_io_req", 32'(io_req), 0);

        do_reset();
        exp_mis = 1'b0;
        exp_ioq = 32'h0;
        for (int i = 0; i < 300; i++) begin
            logic v, ld, st;
            logic [2:0]  f3;
            logic [1:0]  ws;
            logic [31:0] a, d;
            int r;
            case ($urandom_range(0, 4))
                0: nib = 4'h1;
                1: nib = 4'h4;
                2: nib = 4'h0;
                3: nib = 4'h2;
                default: nib = 4'hF;
            endcase
            a  = {nib, 28'($urandom)};
            d  = $urandom;
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 2);
            ld = (r == 0);
            st = (r == 1);
            f3 = 3'($urandom);
            ws = 2'($urandom);
            @(negedge clk);
            drive(v, ld, st, f3, ws, a, d);
            io_ack   = 1'($urandom);
            io_rdata = $urandom;
            model(v, ld, st, f3, a, d, en, we, wd, ben, mis, dsel);
            #1;
            chk("rnd_dmem_en", 32'(dmem_en), 32'(en));
            chk("rnd_dmem_we", 32'(dmem_we), 32'(we));
            chk("rnd_dmem_wdata", dmem_wdata, wd);
            chk("rnd_bios_en", 32'(bios_en), 32'(ben));
            chk("rnd_stall", 32'(stall), 0);
            exp_mis = exp_mis | mis;
            @(posedge clk);
            #1;
            chk("rnd_misalign", 32'(misalign), 32'(exp_mis));
            chk("rnd_wb_dmem_sel", 32'(wb_dmem_sel), 32'(dsel));
            chk("rnd_wb_load_sel", 32'(wb_load_sel), v ? 32'(f3) : 0);
            chk("rnd_wb_sel", 32'(wb_sel), v ? 32'(ws) : 0);
            chk("rnd_io_req", 32'(io_req), 0);
            chk("rnd_io_data_q", io_data_q, exp_ioq);
        end
        io_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences every data-memory access issued by the EXE stage of the three-stage pipeline. It decodes the address region (DMEM, BIOS, IO) and generates DMEM byte write-enables with aligned store data. It runs a req/ack handshake with the IO bus and stalls the pipeline while IO is outstanding. It registers the dmem/load/wb select codes so they arrive at the WB stage aligned with the synchronous-read memory data.

Parameters:
IO_TIMEOUT, 16, max cycles to wait for io_ack before aborting the access
ADDR_W, 32, address width

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
exe_valid  in  1  EXE holds a real (non-bubble) instruction
exe_is_load  in  1  instruction is a load
exe_is_store  in  1  instruction is a store
exe_funct3  in  3  RISC-V funct3 of load/store
exe_wb_sel  in  2  WB source from decoder: 0 imm, 1 pc+4, 2 mem, 3 alu
exe_addr  in  ADDR_W  effective address (ALU result)
exe_wdata  in  32  store data from rs2
dmem_en  out  1  DMEM port enable (comb)
dmem_we  out  4  DMEM byte write-enables (comb)
dmem_wdata  out  32  store data shifted to byte lane (comb)
bios_en  out  1  BIOS read enable (comb)
io_req  out  1  IO request, held until ack
io_we  out  1  IO request is a write
io_addr  out  ADDR_W  IO address, stable while io_req
io_wdata  out  32  IO write data, stable while io_req
io_ack  in  1  IO completes request this cycle
io_rdata  in  32  IO read data, valid with io_ack
io_data_q  out  32  captured IO read data presented to WB
stall  out  1  freeze PC and EXE register (comb)
wb_dmem_sel  out  2  WB raw-data mux select: 0 io, 1 dmem, 2 bios
wb_load_sel  out  3  WB load-unit type (= funct3)
wb_sel  out  2  WB result mux select
misalign  out  1  sticky: a misaligned store or IO timeout occurred

Behaviour:
- Region decode on exe_addr[31:28]: 4'b0001 DMEM, 4'b0100 BIOS (read only), 4'b1000 IO; any other value selects no region (access ignored; loads return the DMEM path).
- Store lane generation: sb -> we = 4'b0001 << addr[1:0], data replicated per byte. sh -> addr[1]=0 gives 4'b0011, addr[1]=1 gives 4'b1100. sw -> 4'b1111.
- Misaligned store (sh with addr[0]=1; sw with addr[1:0]!=0): we=0, misalign set.
- BIOS and unmapped stores: we=0.
- dmem_en = exe_valid & DMEM region & (load|store); bios_en likewise for BIOS loads. No DMEM/BIOS access while in IO_WAIT.
- FSM states:
  - IDLE: on exe_valid & IO region & (load|store), go to IO_WAIT. io_req rises the next cycle. Addr, data and we are registered at entry. stall asserts combinationally in the entry cycle.
  - IO_WAIT: io_req=1 and stall=1. A 5-bit-min counter increments each cycle. On io_ack, latch io_rdata into io_data_q (loads only) and go to IO_DONE. If the counter reaches IO_TIMEOUT-1 without ack, io_data_q=0, set misalign, go to IO_DONE.
  - IO_DONE: stall=0, io_req=0, go to IDLE. The held instruction advances this cycle.
- io_ack outside IO_WAIT is ignored. io_ack in the same cycle as a timeout: ack wins.
- WB select registers update every cycle when stall=0 and hold when stall=1.
  - Bubble (exe_valid=0): load 0, i.e. sel codes 0.
  - Otherwise: wb_dmem_sel from region (IO=0, DMEM=1, BIOS=2, unmapped=1), wb_load_sel=funct3, wb_sel=exe_wb_sel.
- Latency: DMEM/BIOS loads take 1 cycle, with data and select codes in WB the next cycle. IO access takes 3 cycles minimum (entry, wait with ack, done), plus extra wait cycles.
- Reset values: state IDLE; counter 0; io_req 0; io_we 0; io_addr 0; io_wdata 0; io_data_q 0; wb_* 0; misalign 0. Combinational outputs evaluate to 0 when exe_valid=0.
- Reset mid IO_WAIT: abandon immediately, drop io_req next edge, no data latched.
- misalign clears only on rst.

Decomposition:
- Shared package mem_map_pkg holds: region base nibbles, DMEM_SEL_IO/DMEM/BIOS codes, WB_SEL_IMM/PC4/MEM/ALU codes, funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW, and the FSM state enum.
- One natural sub-module, store_lane_gen: combinational funct3 + addr[1:0] + wdata -> we, shifted data, misaligned.

Test Plan:
- sb to 0x1000_0003 with wdata 0x0000_00AB -> dmem_we=4'b1000, dmem_wdata=0xABAB_ABAB, stall=0, misalign=0.
- sw to 0x1000_0002 -> dmem_we=0, misalign=1 next cycle and held until rst.
- lhu from 0x4000_0010 -> bios_en=1; next cycle wb_dmem_sel=2, wb_load_sel=3'b101, wb_sel=2.
- lw from 0x8000_0008, io_ack after 2 wait cycles with io_rdata=0xDEAD_BEEF -> stall high 3 cycles, io_req high 2 cycles, io_data_q=0xDEAD_BEEF, wb_dmem_sel=0 after release.
- IO store with no ack, IO_TIMEOUT=16 -> io_req drops after 16 cycles, misalign=1, stall releases after IO_DONE.
- rst asserted mid IO_WAIT -> next edge: io_req=0, state IDLE, all wb_* = 0; a subsequent exe_valid=0 bubble keeps wb_sel=0.
